pe_gnt_enc_w256: RTL and testbench
==================================

Name: pe_gnt_enc_w256

Overview:
- Downstream stage of the 256-wide fixed-priority encoder.
- Accepts the one-hot grant vector and its valid, and registers it into a 2-entry buffer.
- Presents each grant as a one-hot vector plus an 8-bit binary index on a valid/ready interface.
- On every consumed grant, updates a thermometer priority mask that is fed back upstream to mask requests, turning the fixed-priority encoder into a round-robin (programmable-priority) arbiter.

Parameters:
- W, 256, grant vector width.
- IW, 8, index width; must equal log2(W).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- gnt_in  input  W  one-hot grant from encoder
- gnt_valid  input  1  gnt_in is meaningful (encoder valid)
- gnt_ready  output  1  block can accept gnt_in this cycle
- gnt_out  output  W  registered one-hot grant, head of buffer
- idx_out  output  IW  binary index of gnt_out
- idx_valid  output  1  head entry valid
- idx_ready  input  1  consumer accepts head entry
- pri_mask  output  W  bits strictly above last consumed index set; upstream ANDs Req with it for the masked pass
- err_clr  input  1  synchronous clear of sticky error flags
- err_multi  output  1  sticky: accepted gnt_in had more than one bit set
- err_zero  output  1  sticky: gnt_in was all-zero while gnt_valid=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: count=0, idx_valid=0, gnt_out=0, idx_out=0, pri_mask=0, err_multi=0, err_zero=0, gnt_ready=1.
  - Reset mid-operation flushes both buffer entries.
  - Buffered grants are lost and the mask returns to 0.
- Push:
  - A push occurs when gnt_valid && gnt_ready && (gnt_in != 0).
  - gnt_valid && gnt_ready && gnt_in==0: nothing is pushed; err_zero sets next cycle.
- Encode:
  - idx = index of the lowest set bit of gnt_in.
  - The stored one-hot is the isolated lowest set bit, not raw gnt_in.
  - If popcount(gnt_in) > 1 on a push, err_multi sets next cycle, and the lowest-bit entry is still pushed.
- Buffer: 2-entry FIFO holding {one-hot, idx}, with registered count 0..2.
  - gnt_ready = (count < 2), decoded from registered state only. There is no combinational path idx_ready -> gnt_ready.
  - Pop when idx_valid && idx_ready.
  - idx_valid = (count != 0). gnt_out and idx_out show the head entry and are 0 when the buffer is empty.
- Latency: a grant pushed in cycle N into an empty buffer appears with idx_valid=1 in cycle N+1.
- Simultaneous events:
  - count=1 with push and pop: count stays 1, and the new entry becomes head in the next cycle.
  - count=2: no push is possible. A pop drops count to 1, and gnt_ready=1 the following cycle.
  - count=0 with a pop request: ignored, since idx_valid=0.
- Mask update, on pop only:
  - pri_mask <= {W{1'b1}} << (idx_out+1), i.e. bits idx_out+1..W-1 set.
  - idx_out = W-1: pri_mask <= 0 (wrap-around; full priority returns to bit 0).
  - The mask is never updated on push or on a discarded zero grant.
- Errors:
  - err_clr=1 clears both flags in the next cycle.
  - If a set condition and err_clr occur in the same cycle, set wins.
- Arithmetic: idx is unsigned IW bits. The mask shift amount is computed in IW+1 bits so that W-1+1 does not alias to 0.

Test Plan:
- Reset release, gnt_in=1<<5, gnt_valid=1 for one cycle, idx_ready=1 -> next cycle idx_valid=1, idx_out=5, gnt_out=1<<5. The cycle after: pri_mask has bits 6..255 set, bits 0..5 clear, and count=0.
- idx_ready=0, push grants at bits 3, 7, 9 on consecutive cycles -> gnt_ready=0 after the second push. Bit 9 must be held by the sender; no loss. Then idx_ready=1 -> idx_out sequence 3, 7, 9, and final pri_mask = bits 10..255.
- Push bit 255 and pop -> pri_mask = 0. Then push bit 0 and pop -> pri_mask = bits 1..255.
- gnt_in = (1<<4)|(1<<200), gnt_valid=1 -> entry idx_out=4, gnt_out=1<<4, err_multi=1. Pulse err_clr -> err_multi=0 next cycle.
- gnt_valid=1, gnt_in=0 -> no entry pushed, idx_valid stays 0, pri_mask unchanged, err_zero=1.
- Two entries buffered, assert rst_n=0 asynchronously mid-cycle -> idx_valid, gnt_out, idx_out, pri_mask and errors are 0 immediately, and gnt_ready=1.

Source files
------------

// File: rtl/pe_gnt_enc_w256.sv
// Grant encoder back end: buffers one-hot grants in a 2-deep FIFO, presents them with a binary
// index, and keeps a thermometer mask above the last consumed grant to make the upstream arbiter round-robin.
module pe_gnt_enc_w256 #(
  parameter int W  = 256,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  gnt_in,
  input  logic          gnt_valid,
  output logic          gnt_ready,
  output logic [W-1:0]  gnt_out,
  output logic [IW-1:0] idx_out,
  output logic          idx_valid,
  input  logic          idx_ready,
  output logic [W-1:0]  pri_mask,
  input  logic          err_clr,
  output logic          err_multi,
  output logic          err_zero
);

  typedef struct packed {
    logic [W-1:0]  oh;
    logic [IW-1:0] idx;
  } entry_t;

  entry_t        ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]    count_q, count_d;
  logic [W-1:0]  mask_q, mask_d;
  logic          err_multi_q, err_multi_d, err_zero_q, err_zero_d;

  entry_t        new_ent;
  logic          push, pop, zero_set, multi_set;
  logic [IW:0]   shamt;

  // Ready and valid decode only registered state, so nothing combinational links idx_ready to gnt_ready.
  assign gnt_ready = (count_q != 2'd2);
  assign idx_valid = (count_q != 2'd0);
  assign gnt_out   = idx_valid ? ent0_q.oh  : '0;
  assign idx_out   = idx_valid ? ent0_q.idx : '0;
  assign pri_mask  = mask_q;
  assign err_multi = err_multi_q;
  assign err_zero  = err_zero_q;

  assign push      = gnt_valid && gnt_ready && (|gnt_in);
  assign pop       = idx_valid && idx_ready;
  assign zero_set  = gnt_valid && gnt_ready && !(|gnt_in);
  assign multi_set = push && (|(gnt_in & (gnt_in - W'(1))));

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    new_ent.oh  = gnt_in & (~gnt_in + W'(1));
    new_ent.idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (gnt_in[i]) new_ent.idx = IW'(i);
    end
  end

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (pop && push) begin
      // Only reachable with one entry held: the new grant replaces the departing head.
      ent0_d = new_ent;
    end else if (pop) begin
      ent0_d  = ent1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) ent0_d = new_ent;
      else                 ent1_d = new_ent;
      count_d = count_q + 2'd1;
    end
  end

  // Shift amount is one bit wider than the index so W-1+1 shifts every bit out (wrap to an all-zero mask).
  assign shamt = {1'b0, ent0_q.idx} + (IW+1)'(1);

  always_comb begin
    mask_d      = mask_q;
    err_multi_d = multi_set | (err_multi_q & ~err_clr);
    err_zero_d  = zero_set  | (err_zero_q  & ~err_clr);
    if (pop) mask_d = {W{1'b1}} << shamt;
  end

  // NOTE: the two buffer entries are reset along with the control state; they are only two registers wide,
  // and a known value keeps gnt_out/idx_out clean after a mid-operation flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q      <= '0;
      ent1_q      <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      err_multi_q <= 1'b0;
      err_zero_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      err_multi_q <= err_multi_d;
      err_zero_q  <= err_zero_d;
    end
  end

endmodule

// File: tb/tb_pe_gnt_enc_w256.sv
// Self-checking bench for pe_gnt_enc_w256: directed scenarios plus random traffic against a queue-based
// reference model of the grant FIFO, priority mask and sticky error flags.
module tb_pe_gnt_enc_w256;
  localparam int W  = 256;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  gnt_in;
  logic          gnt_valid;
  logic          gnt_ready;
  logic [W-1:0]  gnt_out;
  logic [IW-1:0] idx_out;
  logic          idx_valid;
  logic          idx_ready;
  logic [W-1:0]  pri_mask;
  logic          err_clr;
  logic          err_multi;
  logic          err_zero;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int           mq[$];
  logic [W-1:0] m_mask;
  logic         m_em, m_ez;

  always #5 clk = ~clk;

  pe_gnt_enc_w256 #(.W(W), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .gnt_in(gnt_in), .gnt_valid(gnt_valid), .gnt_ready(gnt_ready),
    .gnt_out(gnt_out), .idx_out(idx_out), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .pri_mask(pri_mask), .err_clr(err_clr), .err_multi(err_multi), .err_zero(err_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] bit_of(input int b);
    logic [W-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] bits_above(input int b);
    logic [W-1:0] v;
    for (int j = 0; j < W; j++) v[j] = (j > b);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mask = '0;
    m_em   = 1'b0;
    m_ez   = 1'b0;
  endtask

  task automatic compare_all();
    check("gnt_ready", W'(gnt_ready), W'(mq.size() < 2));
    check("idx_valid", W'(idx_valid), W'(mq.size() != 0));
    check("idx_out",   W'(idx_out),   (mq.size() != 0) ? W'(mq[0]) : '0);
    check("gnt_out",   gnt_out,       (mq.size() != 0) ? bit_of(mq[0]) : '0);
    check("pri_mask",  pri_mask,      m_mask);
    check("err_multi", W'(err_multi), W'(m_em));
    check("err_zero",  W'(err_zero),  W'(m_ez));
  endtask

  task automatic model_update();
    bit rdy, pop, push, zset, mset;
    int low, h;
    rdy  = (mq.size() < 2);
    pop  = (mq.size() != 0) && idx_ready;
    push = gnt_valid && rdy && (gnt_in != '0);
    zset = gnt_valid && rdy && (gnt_in == '0);
    mset = push && ($countones(gnt_in) > 1);
    low  = -1;
    for (int j = W - 1; j >= 0; j--) if (gnt_in[j]) low = j;
    if (pop) begin
      h = mq.pop_front();
      m_mask = bits_above(h);
    end
    if (push) mq.push_back(low);
    m_em = mset ? 1'b1 : (err_clr ? 1'b0 : m_em);
    m_ez = zset ? 1'b1 : (err_clr ? 1'b0 : m_ez);
  endtask

  // Drive inputs just after a rising edge, compare at the falling edge, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] g, input logic r, input logic c);
    gnt_valid = v;
    gnt_in    = g;
    idx_ready = r;
    err_clr   = c;
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] g;
    int mode;
    rst_n = 1'b0; gnt_valid = 1'b0; gnt_in = '0; idx_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single grant at bit 5, consumed immediately
    step(1'b1, bit_of(5), 1'b1, 1'b0);
    check("plan1_idx", W'(idx_out), W'(5));
    step(1'b0, '0, 1'b1, 1'b0);
    check("plan1_mask", pri_mask, {W{1'b1}} << 6);
    check("plan1_empty", W'(idx_valid), '0);

    // Fill the buffer with 3 and 7; 9 is held until accepted, then drain
    step(1'b1, bit_of(3), 1'b0, 1'b0);
    step(1'b1, bit_of(7), 1'b0, 1'b0);
    check("plan2_full", W'(gnt_ready), '0);
    step(1'b1, bit_of(9), 1'b0, 1'b0);
    step(1'b1, bit_of(9), 1'b1, 1'b0);
    step(1'b1, bit_of(9), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("plan2_mask", pri_mask, {W{1'b1}} << 10);

    // Wrap-around at bit 255, then bit 0
    step(1'b1, bit_of(255), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("plan3_wrap", pri_mask, '0);
    step(1'b1, bit_of(0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("plan3_bit0", pri_mask, {W{1'b1}} << 1);

    // Multi-bit grant and error clear
    step(1'b1, bit_of(4) | bit_of(200), 1'b0, 1'b0);
    check("plan4_idx", W'(idx_out), W'(4));
    check("plan4_err", W'(err_multi), W'(1));
    step(1'b0, '0, 1'b1, 1'b1);
    check("plan4_clr", W'(err_multi), '0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Zero grant: nothing pushed, mask unchanged
    step(1'b1, '0, 1'b1, 1'b0);
    check("plan5_err", W'(err_zero), W'(1));
    check("plan5_empty", W'(idx_valid), '0);
    check("plan5_mask", pri_mask, {W{1'b1}} << 5);

    // Asynchronous reset with two buffered entries
    step(1'b1, bit_of(17), 1'b0, 1'b0);
    step(1'b1, bit_of(42), 1'b0, 1'b0);
    gnt_valid = 1'b0; gnt_in = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_ready", W'(gnt_ready), W'(1));
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      mode = $urandom_range(0, 15);
      case (mode)
        0:       g = '0;
        1:       g = bit_of($urandom_range(0, W - 1)) | bit_of($urandom_range(0, W - 1));
        2:       g = bit_of(W - 1);
        3:       g = bit_of(0);
        default: g = bit_of($urandom_range(0, W - 1));
      endcase
      step(($urandom_range(0, 3) != 0), g, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
